// File: rtl/slurm16_mem_pkg.sv
// Shared helpers for the SLURM16 banked memory arbiter: a constant-function
// CLOG2 and the grant-field encoding shared by the top and the bank arbiters.
package slurm16_mem_pkg;

  // Ceiling log2 usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Width of a grant field. It encodes ports 0..num_ports-1 plus the CPU.
  function automatic int grant_bits(input int num_ports);
    return clog2(num_ports + 1);
  endfunction

  // Grant value meaning "the CPU owns the bank".
  function automatic int grant_cpu(input int num_ports);
    return num_ports;
  endfunction

endpackage

// File: rtl/slurm16_bank_arbiter.sv
// One bank's arbiter. It holds the round-robin pointer over the peripheral
// ports and the CPU anti-starvation counter. It produces this cycle's grant
// and the bank-side address/data/mask/write signals for the winner.
module slurm16_bank_arbiter
  import slurm16_mem_pkg::*;
#(
  parameter int NUM_PORTS      = 3,
  parameter int BANK_ADDR_BITS = 14,
  parameter int DATA_BITS      = 16,
  parameter int MAX_HOLD       = 8,
  parameter int GRANT_BITS     = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                req,
  input  logic [NUM_PORTS-1:0]                periph_wr,
  input  logic [NUM_PORTS*BANK_ADDR_BITS-1:0] periph_addr,
  input  logic [NUM_PORTS*DATA_BITS-1:0]      periph_wdata,
  input  logic                                cpu_target,
  input  logic                                cpu_wr,
  input  logic [BANK_ADDR_BITS-1:0]           cpu_addr,
  input  logic [DATA_BITS-1:0]                cpu_wdata,
  input  logic [DATA_BITS/8-1:0]              cpu_wr_mask,
  output logic [GRANT_BITS-1:0]               grant,
  output logic [BANK_ADDR_BITS-1:0]           bank_addr,
  output logic [DATA_BITS-1:0]                bank_din,
  output logic [DATA_BITS/8-1:0]              bank_mask,
  output logic                                bank_wr
);

  localparam int PTR_BITS = (NUM_PORTS > 1) ? clog2(NUM_PORTS) : 1;
  localparam int CNT_BITS = (MAX_HOLD > 0) ? clog2(MAX_HOLD + 1) : 1;
  localparam logic [GRANT_BITS-1:0] GRANT_CPU = GRANT_BITS'(grant_cpu(NUM_PORTS));
  localparam logic [CNT_BITS-1:0]   HOLD_MAX  = CNT_BITS'(MAX_HOLD);

  logic [PTR_BITS-1:0] last_grant;
  logic [CNT_BITS-1:0] hold_cnt;
  logic [PTR_BITS-1:0] rr_pick;
  logic                rr_found;
  logic                cpu_force;
  logic                port_won;

  // Round-robin search: first requesting port after last_grant, with wrap-around.
  always_comb begin
    int idx;
    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (which would infer a latch).
    idx      = 0;
    rr_pick  = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!rr_found && req[idx[PTR_BITS-1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = idx[PTR_BITS-1:0];
      end
    end
  end

  // Grant priority: a starved CPU first, then the round-robin winner, else the CPU by default.
  always_comb begin
    cpu_force = (MAX_HOLD != 0) && cpu_target && (hold_cnt == HOLD_MAX);
    if (cpu_force)     grant = GRANT_CPU;
    else if (rr_found) grant = GRANT_BITS'(rr_pick);
    else               grant = GRANT_CPU;
    port_won = (grant != GRANT_CPU);
  end

  // Bank mux: the CPU drives the bank unless a peripheral won it; peripheral writes use the full mask.
  always_comb begin
    bank_addr = cpu_addr;
    bank_din  = cpu_wdata;
    bank_mask = cpu_wr_mask;
    bank_wr   = cpu_target & cpu_wr;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_won && (grant == GRANT_BITS'(p))) begin
        bank_addr = periph_addr[p*BANK_ADDR_BITS +: BANK_ADDR_BITS];
        bank_din  = periph_wdata[p*DATA_BITS +: DATA_BITS];
        bank_mask = '1;
        bank_wr   = periph_wr[p];
      end
    end
  end

  // Round-robin pointer moves only when a peripheral is granted; reset makes port 0 win first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
      last_grant <= PTR_BITS'(NUM_PORTS - 1);
    end else if (port_won) begin
      last_grant <= rr_pick;
    end
  end

  // Starvation counter: counts peripheral wins while the CPU waits here, saturating at MAX_HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (MAX_HOLD == 0) begin
      hold_cnt <= '0;
    end else if (port_won && cpu_target) begin
      if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + CNT_BITS'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

endmodule

// File: rtl/slurm16_banked_memory_arbiter.sv
// SLURM16 banked memory arbiter. It connects one CPU port and NUM_PORTS
// peripheral ports to NUM_BANKS single-port BRAM banks. Each bank is
// arbitrated independently. Acknowledges and read data return one cycle
// after the grant, steered by the grants registered here.
module slurm16_banked_memory_arbiter
  import slurm16_mem_pkg::*;
#(
  parameter int                               NUM_BANKS      = 4,
  parameter int                               NUM_PORTS      = 3,
  parameter int                               ADDR_BITS      = 16,
  parameter int                               DATA_BITS      = 16,
  parameter logic [NUM_PORTS*NUM_BANKS-1:0]   PORT_BANK_MASK = '1,
  parameter int                               MAX_HOLD       = 8
) (
  input  logic                                                   CLK,
  input  logic                                                   RSTb,
  input  logic [NUM_PORTS-1:0]                                   periph_valid,
  input  logic [NUM_PORTS-1:0]                                   periph_wr,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]                         periph_addr,
  input  logic [NUM_PORTS*DATA_BITS-1:0]                         periph_wdata,
  output logic [NUM_PORTS-1:0]                                   periph_ready,
  output logic [NUM_PORTS*DATA_BITS-1:0]                         periph_rdata,
  output logic [NUM_PORTS-1:0]                                   periph_err,
  input  logic                                                   cpu_valid,
  input  logic                                                   cpu_wr,
  input  logic [ADDR_BITS-1:0]                                   cpu_addr,
  input  logic [DATA_BITS-1:0]                                   cpu_wdata,
  input  logic [DATA_BITS/8-1:0]                                 cpu_wr_mask,
  output logic [DATA_BITS-1:0]                                   cpu_rdata,
  output logic                                                   cpu_memory_success,
  output logic [NUM_BANKS*(ADDR_BITS-clog2(NUM_BANKS))-1:0]      B_ADDR,
  output logic [NUM_BANKS*DATA_BITS-1:0]                         B_DIN,
  input  logic [NUM_BANKS*DATA_BITS-1:0]                         B_DOUT,
  output logic [NUM_BANKS*(DATA_BITS/8)-1:0]                     B_MASK,
  output logic [NUM_BANKS-1:0]                                   B_WR
);

  localparam int BANK_BITS      = clog2(NUM_BANKS);
  localparam int BANK_ADDR_BITS = ADDR_BITS - BANK_BITS;
  localparam int MASK_BITS      = DATA_BITS / 8;
  localparam int GRANT_BITS     = grant_bits(NUM_PORTS);
  localparam logic [GRANT_BITS-1:0] GRANT_CPU = GRANT_BITS'(grant_cpu(NUM_PORTS));

  logic [BANK_BITS-1:0]                port_bank [NUM_PORTS];
  logic [NUM_PORTS-1:0]                port_allowed;
  logic [NUM_PORTS-1:0]                periph_denied;
  logic [NUM_PORTS*BANK_ADDR_BITS-1:0] port_bank_addr;
  logic [NUM_PORTS-1:0]                bank_req [NUM_BANKS];
  logic [BANK_BITS-1:0]                cpu_bank;
  logic [NUM_BANKS-1:0]                cpu_target;
  logic [GRANT_BITS-1:0]               grant   [NUM_BANKS];
  logic [GRANT_BITS-1:0]               grant_q [NUM_BANKS];
  logic [BANK_BITS-1:0]                cpu_bank_q;
  logic [NUM_PORTS-1:0]                periph_granted;
  logic                                cpu_granted;

  assign cpu_bank = cpu_addr[ADDR_BITS-1 -: BANK_BITS];

  // Decode each port's target bank and permission, and build per-bank request vectors.
  always_comb begin
    port_allowed   = '0;
    periph_denied  = '0;
    port_bank_addr = '0;
    for (int b = 0; b < NUM_BANKS; b++) bank_req[b] = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_bank[p] = periph_addr[p*ADDR_BITS + ADDR_BITS-1 -: BANK_BITS];
      port_bank_addr[p*BANK_ADDR_BITS +: BANK_ADDR_BITS] = periph_addr[p*ADDR_BITS +: BANK_ADDR_BITS];
      port_allowed[p]  = PORT_BANK_MASK[p*NUM_BANKS + int'(port_bank[p])];
      periph_denied[p] = periph_valid[p] & ~port_allowed[p];
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (periph_valid[p] && port_allowed[p] && (port_bank[p] == BANK_BITS'(b)))
          bank_req[b][p] = 1'b1;
      end
    end
  end

  // CPU target decode, one bit per bank.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++)
      cpu_target[b] = cpu_valid && (cpu_bank == BANK_BITS'(b));
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    slurm16_bank_arbiter #(
      .NUM_PORTS      (NUM_PORTS),
      .BANK_ADDR_BITS (BANK_ADDR_BITS),
      .DATA_BITS      (DATA_BITS),
      .MAX_HOLD       (MAX_HOLD),
      .GRANT_BITS     (GRANT_BITS)
    ) u_arb (
      .clk          (CLK),
      .rst_n        (RSTb),
      .req          (bank_req[b]),
      .periph_wr    (periph_wr),
      .periph_addr  (port_bank_addr),
      .periph_wdata (periph_wdata),
      .cpu_target   (cpu_target[b]),
      .cpu_wr       (cpu_wr),
      .cpu_addr     (cpu_addr[BANK_ADDR_BITS-1:0]),
      .cpu_wdata    (cpu_wdata),
      .cpu_wr_mask  (cpu_wr_mask),
      .grant        (grant[b]),
      .bank_addr    (B_ADDR[b*BANK_ADDR_BITS +: BANK_ADDR_BITS]),
      .bank_din     (B_DIN[b*DATA_BITS +: DATA_BITS]),
      .bank_mask    (B_MASK[b*MASK_BITS +: MASK_BITS]),
      .bank_wr      (B_WR[b])
    );
  end

  // Reduce per-bank grants to per-port and CPU completion flags.
  always_comb begin
    periph_granted = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant[b] == GRANT_BITS'(p)) periph_granted[p] = 1'b1;
      end
    end
    cpu_granted = cpu_valid && (grant[cpu_bank] == GRANT_CPU);
  end

  // Register grants and acknowledges so read data and status line up with B_DOUT.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      // NOTE: the grant array is control state, so every entry is reset; plain data storage would not need this.
      for (int b = 0; b < NUM_BANKS; b++) grant_q[b] <= GRANT_CPU;
      cpu_bank_q         <= '0;
      periph_ready       <= '0;
      periph_err         <= '0;
      cpu_memory_success <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) grant_q[b] <= grant[b];
      cpu_bank_q         <= cpu_bank;
      periph_ready       <= periph_granted;
      periph_err         <= periph_denied;
      cpu_memory_success <= cpu_granted;
    end
  end

  // Read-data return: the CPU reads the bank it addressed, each port reads the bank it was granted.
  always_comb begin
    cpu_rdata    = B_DOUT[int'(cpu_bank_q)*DATA_BITS +: DATA_BITS];
    periph_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (grant_q[b] == GRANT_BITS'(p))
          periph_rdata[p*DATA_BITS +: DATA_BITS] = B_DOUT[b*DATA_BITS +: DATA_BITS];
      end
    end
  end

endmodule

// File: tb/tb_slurm16_banked_memory_arbiter.sv
// Self-checking bench for slurm16_banked_memory_arbiter. It uses directed
// vectors with hand-computed results, plus sequences for round-robin
// rotation, CPU anti-starvation and asynchronous reset mid-stream.
// Port 1 is denied access to bank 0.
`timescale 1ns/1ps
module tb_slurm16_banked_memory_arbiter;

  localparam int NB  = 4;
  localparam int NP  = 3;
  localparam int AB  = 16;
  localparam int DB  = 16;
  localparam int BAB = 14;
  localparam int MB  = 2;

  logic             CLK = 1'b0;
  logic             RSTb;
  logic [NP-1:0]    periph_valid, periph_wr, periph_ready, periph_err;
  logic [NP*AB-1:0] periph_addr;
  logic [NP*DB-1:0] periph_wdata, periph_rdata;
  logic             cpu_valid, cpu_wr, cpu_memory_success;
  logic [AB-1:0]    cpu_addr;
  logic [DB-1:0]    cpu_wdata, cpu_rdata;
  logic [MB-1:0]    cpu_wr_mask;
  logic [NB*BAB-1:0] B_ADDR;
  logic [NB*DB-1:0] B_DIN, B_DOUT;
  logic [NB*MB-1:0] B_MASK;
  logic [NB-1:0]    B_WR;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  slurm16_banked_memory_arbiter #(
    .NUM_BANKS(NB), .NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB),
    .PORT_BANK_MASK(12'hFEF), .MAX_HOLD(8)
  ) dut (
    .CLK(CLK), .RSTb(RSTb),
    .periph_valid(periph_valid), .periph_wr(periph_wr), .periph_addr(periph_addr),
    .periph_wdata(periph_wdata), .periph_ready(periph_ready), .periph_rdata(periph_rdata),
    .periph_err(periph_err),
    .cpu_valid(cpu_valid), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wr_mask(cpu_wr_mask), .cpu_rdata(cpu_rdata), .cpu_memory_success(cpu_memory_success),
    .B_ADDR(B_ADDR), .B_DIN(B_DIN), .B_DOUT(B_DOUT), .B_MASK(B_MASK), .B_WR(B_WR)
  );

  // Byte-masked single-port BRAM banks with one-cycle read latency.
  logic [DB-1:0] mem [NB][2**BAB];
  always @(posedge CLK) begin
    for (int b = 0; b < NB; b++) begin
      if (B_WR[b]) begin
        for (int k = 0; k < MB; k++) begin
          if (B_MASK[b*MB+k])
            mem[b][B_ADDR[b*BAB +: BAB]][k*8 +: 8] <= B_DIN[b*DB + k*8 +: 8];
        end
      end
      B_DOUT[b*DB +: DB] <= mem[b][B_ADDR[b*BAB +: BAB]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          cv, cw;
    logic [15:0]   caddr, cwdata;
    logic [1:0]    cmask;
    logic [2:0]    pv, pw;
    logic [47:0]   paddr, pwdata;
    logic [3:0]    exp_bwr;
    logic          chk_ba0;
    logic [13:0]   exp_ba0;
    logic          exp_succ;
    logic [2:0]    exp_ready, exp_err;
    logic          chk_crd;
    logic [15:0]   exp_crd;
    int            prd_port;
    logic [15:0]   exp_prd;
  } vec_t;

  function automatic vec_t mk(
    input logic cv, input logic cw, input logic [15:0] caddr, input logic [15:0] cwdata,
    input logic [1:0] cmask, input logic [2:0] pv, input logic [2:0] pw,
    input logic [47:0] paddr, input logic [47:0] pwdata, input logic [3:0] exp_bwr,
    input logic chk_ba0, input logic [13:0] exp_ba0, input logic exp_succ,
    input logic [2:0] exp_ready, input logic [2:0] exp_err, input logic chk_crd,
    input logic [15:0] exp_crd, input int prd_port, input logic [15:0] exp_prd);
    vec_t v;
    v.cv = cv; v.cw = cw; v.caddr = caddr; v.cwdata = cwdata; v.cmask = cmask;
    v.pv = pv; v.pw = pw; v.paddr = paddr; v.pwdata = pwdata; v.exp_bwr = exp_bwr;
    v.chk_ba0 = chk_ba0; v.exp_ba0 = exp_ba0; v.exp_succ = exp_succ;
    v.exp_ready = exp_ready; v.exp_err = exp_err; v.chk_crd = chk_crd; v.exp_crd = exp_crd;
    v.prd_port = prd_port; v.exp_prd = exp_prd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    cpu_valid = v.cv; cpu_wr = v.cw; cpu_addr = v.caddr; cpu_wdata = v.cwdata;
    cpu_wr_mask = v.cmask; periph_valid = v.pv; periph_wr = v.pw;
    periph_addr = v.paddr; periph_wdata = v.pwdata;
  endtask

  task automatic idle();
    cpu_valid = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wr_mask = '0;
    periph_valid = '0; periph_wr = '0; periph_addr = '0; periph_wdata = '0;
  endtask

  // Three ports reading bank 2 (0x8000, 0x8001, 0x8002), CPU idle.
  task automatic drive_bank2_all();
    idle();
    periph_valid = 3'b111;
    periph_addr  = {16'h8002, 16'h8001, 16'h8000};
  endtask

  vec_t vecs[11];
  int   ready_cnt[NP];
  logic exp_s;

  initial begin
    // Vector fields: cpu(v,wr,addr,wdata,mask), periph(v,wr,addr{p2,p1,p0},wdata{p2,p1,p0}),
    // B_WR, B_ADDR[0] check, success, ready, err, cpu_rdata check, periph_rdata check.
    vecs[0]  = mk(1,1,16'h0010,16'hBEEF,2'b11, 3'b000,3'b000,48'h0,48'h0, 4'b0001, 1,14'h0010, 1,3'b000,3'b000, 0,16'h0,    -1,16'h0);
    vecs[1]  = mk(1,0,16'h0010,16'h0,2'b00,    3'b000,3'b000,48'h0,48'h0, 4'b0000, 1,14'h0010, 1,3'b000,3'b000, 1,16'hBEEF, -1,16'h0);
    vecs[2]  = mk(1,1,16'h4007,16'h5A5A,2'b11, 3'b000,3'b000,48'h0,48'h0, 4'b0010, 0,14'h0,    1,3'b000,3'b000, 0,16'h0,    -1,16'h0);
    vecs[3]  = mk(1,0,16'h4007,16'h0,2'b00,    3'b100,3'b100,{16'hC005,32'h0},{16'h1234,32'h0}, 4'b1000, 0,14'h0, 1,3'b100,3'b000, 1,16'h5A5A, -1,16'h0);
    vecs[4]  = mk(0,0,16'h0,16'h0,2'b00,       3'b100,3'b000,{16'hC005,32'h0},48'h0, 4'b0000, 0,14'h0, 0,3'b100,3'b000, 0,16'h0, 2,16'h1234);
    vecs[5]  = mk(1,0,16'h0010,16'h0,2'b00,    3'b010,3'b000,{16'h0,16'h0004,16'h0},48'h0, 4'b0000, 1,14'h0010, 1,3'b000,3'b010, 1,16'hBEEF, -1,16'h0);
    vecs[6]  = mk(1,1,16'h0010,16'h1100,2'b10, 3'b000,3'b000,48'h0,48'h0, 4'b0001, 1,14'h0010, 1,3'b000,3'b000, 0,16'h0,    -1,16'h0);
    vecs[7]  = mk(1,0,16'h0010,16'h0,2'b00,    3'b000,3'b000,48'h0,48'h0, 4'b0000, 0,14'h0,    1,3'b000,3'b000, 1,16'h11EF, -1,16'h0);
    vecs[8]  = mk(0,0,16'h0,16'h0,2'b00,       3'b001,3'b001,{32'h0,16'h0021},{32'h0,16'h7777}, 4'b0001, 1,14'h0021, 0,3'b001,3'b000, 0,16'h0, -1,16'h0);
    vecs[9]  = mk(1,0,16'h0010,16'h0,2'b00,    3'b001,3'b000,{32'h0,16'h0021},48'h0, 4'b0000, 1,14'h0021, 0,3'b001,3'b000, 0,16'h0, 0,16'h7777);
    vecs[10] = mk(1,0,16'h0021,16'h0,2'b00,    3'b000,3'b000,48'h0,48'h0, 4'b0000, 1,14'h0021, 1,3'b000,3'b000, 1,16'h7777, -1,16'h0);

    // Reset state.
    idle();
    RSTb = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset periph_ready", 32'(periph_ready), 32'h0);
    check("reset periph_err", 32'(periph_err), 32'h0);
    check("reset cpu_memory_success", 32'(cpu_memory_success), 32'h0);
    check("reset periph_rdata", periph_rdata[31:0], 32'h0);
    RSTb = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      drive(vecs[i]);
      #1;
      check($sformatf("vec%0d B_WR", i), 32'(B_WR), 32'(vecs[i].exp_bwr));
      if (vecs[i].chk_ba0) check($sformatf("vec%0d B_ADDR bank0", i), 32'(B_ADDR[13:0]), 32'(vecs[i].exp_ba0));
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d cpu_memory_success", i), 32'(cpu_memory_success), 32'(vecs[i].exp_succ));
      check($sformatf("vec%0d periph_ready", i), 32'(periph_ready), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d periph_err", i), 32'(periph_err), 32'(vecs[i].exp_err));
      if (vecs[i].chk_crd) check($sformatf("vec%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].exp_crd));
      if (vecs[i].prd_port >= 0)
        check($sformatf("vec%0d periph_rdata[%0d]", i, vecs[i].prd_port),
              32'(periph_rdata[vecs[i].prd_port*DB +: DB]), 32'(vecs[i].exp_prd));
    end

    // Round-robin on bank 2: grants rotate 0,1,2,0,1,2.
    for (int p = 0; p < NP; p++) ready_cnt[p] = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      drive_bank2_all();
      @(posedge CLK);
      #1;
      check($sformatf("rr cycle%0d periph_ready", k), 32'(periph_ready), 32'(3'b001 << (k % 3)));
      for (int p = 0; p < NP; p++) if (periph_ready[p]) ready_cnt[p]++;
    end
    for (int p = 0; p < NP; p++) check($sformatf("rr duty port%0d", p), 32'(ready_cnt[p]), 32'd2);

    // Anti-starvation: port 0 streams bank 0 while the CPU waits on bank 0.
    for (int k = 0; k < 27; k++) begin
      @(negedge CLK);
      idle();
      cpu_valid = 1'b1; cpu_addr = 16'h0030;
      periph_valid = 3'b001; periph_addr = {32'h0, 16'h0040};
      @(posedge CLK);
      #1;
      exp_s = ((k % 9) == 8);
      check($sformatf("hold cycle%0d cpu_memory_success", k), 32'(cpu_memory_success), 32'(exp_s));
      check($sformatf("hold cycle%0d periph_ready[0]", k), 32'(periph_ready[0]), 32'(!exp_s));
    end

    // Asynchronous reset mid-stream, then port 0 wins first again.
    @(negedge CLK);
    drive_bank2_all();
    @(posedge CLK);
    #1;
    check("stream pre-reset grant0", 32'(periph_ready), 32'h1);
    @(negedge CLK);
    @(posedge CLK);
    #1;
    check("stream pre-reset grant1", 32'(periph_ready), 32'h2);
    @(negedge CLK);
    RSTb = 1'b0;
    #1;
    check("async reset periph_ready", 32'(periph_ready), 32'h0);
    check("async reset periph_err", 32'(periph_err), 32'h0);
    check("async reset cpu_memory_success", 32'(cpu_memory_success), 32'h0);
    @(negedge CLK);
    RSTb = 1'b1;
    @(posedge CLK);
    #1;
    check("post-reset first grant", 32'(periph_ready), 32'h1);

    @(negedge CLK);
    idle();
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slurm16_banked_memory_arbiter.md
# slurm16_banked_memory_arbiter

Parametrised successor to the fixed four-bank SLURM16 memory arbiter. It connects one CPU port and NUM_PORTS read/write peripheral ports (sprites, backgrounds, flash, audio, DMA) to NUM_BANKS single-port block-RAM banks. Each bank has its own round-robin arbiter among peripherals, a per-port bank-access mask and a CPU anti-starvation counter. It sits between the CPU/peripherals and the BRAM bank wrappers in the top level.

## Interface
- NUM_BANKS, 4: number of banks; power of two, at least 2.
- NUM_PORTS, 3: number of peripheral ports, 1 to 8.
- ADDR_BITS, 16: word address width; bank index is addr[ADDR_BITS-1 -: log2(NUM_BANKS)].
- DATA_BITS, 16: data width; the mask has DATA_BITS/8 bits.
- PORT_BANK_MASK, all ones: NUM_PORTS*NUM_BANKS bits; bit p*NUM_BANKS+b set means port p may access bank b.
- MAX_HOLD, 8: maximum consecutive peripheral grants on a bank while the CPU waits on that bank; 0 disables the counter.
- CLK  in  1  clock.
- RSTb  in  1  reset, asynchronous and active-low.
- periph_valid  in  NUM_PORTS  request per port.
- periph_wr  in  NUM_PORTS  1 = write, 0 = read.
- periph_addr  in  NUM_PORTS*ADDR_BITS  word address.
- periph_wdata  in  NUM_PORTS*DATA_BITS  write data; peripheral writes always use the full mask.
- periph_ready  out  NUM_PORTS  transfer acknowledge, registered.
- periph_rdata  out  NUM_PORTS*DATA_BITS  read data, valid when periph_ready is high.
- periph_err  out  NUM_PORTS  one-cycle pulse on a request to a bank the port is not allowed to access.
- cpu_valid  in  1  CPU access request.
- cpu_wr  in  1  CPU write.
- cpu_addr  in  ADDR_BITS  CPU word address.
- cpu_wdata  in  DATA_BITS  CPU write data.
- cpu_wr_mask  in  DATA_BITS/8  CPU byte-write mask.
- cpu_rdata  out  DATA_BITS  CPU read data.
- cpu_memory_success  out  1  the access issued last cycle completed; if low, the CPU reissues.
- B_ADDR  out  NUM_BANKS*(ADDR_BITS-log2 NUM_BANKS)  address to each bank.
- B_DIN  out  NUM_BANKS*DATA_BITS  write data to each bank.
- B_DOUT  in  NUM_BANKS*DATA_BITS  read data from each bank, one cycle after the address.
- B_MASK  out  NUM_BANKS*DATA_BITS/8  byte mask to each bank.
- B_WR  out  NUM_BANKS  write enable to each bank.

## Operation
- Targeting: port p targets bank b when periph_valid[p] is high and its bank index equals b.
  - If PORT_BANK_MASK forbids (p, b), the request is never granted and periph_err[p] pulses in cycle t+1.
- Grant, combinational in cycle t, per bank:
  - If the starvation counter equals MAX_HOLD (MAX_HOLD nonzero) and the CPU targets the bank, the CPU is granted.
  - Otherwise, if any allowed port targets the bank, the port granted is the first requesting port after last_grant[b], searching upward with wrap-around.
  - Otherwise the CPU owns the bank by default.
- Bank signals follow the grant combinationally.
  - B_WR is asserted only for a granted write.
  - When the CPU owns the bank by default, B_WR = cpu_valid & cpu_wr & CPU targets the bank.
  - Peripheral writes drive B_MASK to all ones.
- last_grant[b] updates only on a peripheral grant.
- Starvation counter per bank:
  - Increments on a peripheral grant while cpu_valid is high and the CPU targets the bank.
  - Clears on a CPU grant, or when the CPU is not targeting the bank.
  - Saturates at MAX_HOLD.
- Read data is routed by the grant registered in cycle t and selected from B_DOUT in cycle t+1. Each port has at most one grant per cycle because a port targets exactly one bank.
- Streaming: a port holding valid high gets one transfer per granted cycle. A requester that advances its address on periph_ready repeats one access with the old address; this is harmless by design (same address, same data).

## Timing
- Reset values:
  - All periph_ready, periph_err and cpu_memory_success are 0.
  - last_grant = NUM_PORTS-1, so port 0 wins first.
  - Counters = 0; registered grants = CPU.
  - cpu_rdata and periph_rdata follow B_DOUT through the reset-state mux.
- Latency: request and grant in cycle t; periph_ready, periph_rdata, cpu_memory_success and cpu_rdata are valid in cycle t+1. Throughput is one access per bank per cycle.
- cpu_memory_success(t+1) = cpu_valid(t) & CPU granted its target bank in t.
- Simultaneous CPU and peripheral requests on one bank: the peripheral wins unless the counter equals MAX_HOLD.
- Requests to different banks are independent; all banks may complete in the same cycle.
- RSTb assertion mid-transfer clears all state asynchronously. Transfers issued in the cycle of reset are not acknowledged; a write issued in that cycle may or may not land.

## Structure
- Package slurm16_mem_pkg holds:
  - A CLOG2 helper.
  - GRANT_CPU encoding: value NUM_PORTS in a $clog2(NUM_PORTS+1)-bit grant field.
- Sub-module slurm16_bank_arbiter, one instance per bank via generate:
  - Contains the round-robin pointer, starvation counter, grant logic and bank mux.
  - Outputs the grant.
- The top level holds:
  - The registered grants.
  - The ready, err and success flops.
  - The read-data return mux.

## Test plan
- Reset, then CPU write 0xBEEF to 0x0010 and read back: success is high at t+1, and cpu_rdata = 0xBEEF one cycle after the read.
- Ports 0, 1 and 2 request bank 2 continuously: grants rotate 0,1,2,0; each periph_ready shows a 1-in-3 duty.
- MAX_HOLD = 8, port 0 streams bank 0 while the CPU is held on bank 0: cpu_memory_success is high on exactly every 9th cycle.
- PORT_BANK_MASK forbids (1, bank 0), port 1 reads 0x0004: periph_err[1] pulses, periph_ready[1] stays 0, and B_WR/B_ADDR are unaffected.
- Port 2 writes 0x1234 to bank 3 while the CPU reads bank 1 in the same cycle: both complete at t+1 with no conflict.
- Assert RSTb low mid-stream: all outputs are 0 immediately, and after release port 0 wins first.
